// File: rtl/mem_responder.sv
// Multi-cycle load/store responder: one request at a time, fixed LATENCY, Stall while busy.
// Optional alignment check compiled in with MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int LATENCY    = 2,
    parameter int WORDS_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [WORDS_LOG2-1:0] addr_q;
    logic [15:0]           data_q;
    logic                  wr_q;
    logic [15:0]           mem_q [0:(1<<WORDS_LOG2)-1];

    logic                  idle, bad_align, req, valid, fire, acc_wr;
    logic [WORDS_LOG2-1:0] acc_addr;
    logic [15:0]           acc_data;
    logic                  unused_addr_bits;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign bad_align = Addr[0];
`else
    assign bad_align = 1'b0;
`endif
    assign unused_addr_bits = ^Addr;

    // With LATENCY=1 the access completes on the acceptance edge, straight from the inputs.
    always_comb begin
        idle     = (state_q == IDLE);
        req      = Rd | Wr;
        valid    = (Rd ^ Wr) & ~bad_align;
        acc_addr = idle ? Addr[WORDS_LOG2:1] : addr_q;
        acc_data = idle ? DataIn : data_q;
        acc_wr   = idle ? Wr : wr_q;
        fire     = idle ? (valid && (LATENCY == 1)) : (cnt_q == 4'd1);

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    cnt_d = CNT_LOAD;
                    if (LATENCY > 1) state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_d = fire;
        dout_d = (fire && !acc_wr) ? mem_q[acc_addr] : 16'h0000;
        err_d  = idle && req && !valid;
        Stall  = rst && (!idle || valid);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= 16'h0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Request capture and the array carry no reset; a store is dropped if reset hits its commit edge.
    always_ff @(posedge clk) begin
        if (idle && valid) begin
            addr_q <= Addr[WORDS_LOG2:1];
            data_q <= DataIn;
            wr_q   <= Wr;
        end
        if (rst && fire && acc_wr) begin
            mem_q[acc_addr] <= acc_data;
        end
    end

    assign DataOut = dout_q;
    assign Done    = done_q;
    assign err     = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 main instance plus LATENCY=1 and 15 instances.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn;
    logic        Rd, Wr;

    logic [15:0] dout1, dout2, dout15;
    logic        done1, done2, done15;
    logic        stall1, stall2, stall15;
    logic        err1, err2, err15;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2), .WORDS_LOG2(8)) dut2 (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(dout2), .Done(done2), .Stall(stall2), .err(err2));
    mem_responder #(.LATENCY(1), .WORDS_LOG2(8)) dut1 (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(dout1), .Done(done1), .Stall(stall1), .err(err1));
    mem_responder #(.LATENCY(15), .WORDS_LOG2(8)) dut15 (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(dout15), .Done(done15), .Stall(stall15), .err(err15));

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        Rd = rd;
        Wr = wr;
        Addr = a;
        DataIn = d;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One LATENCY=2 transaction on dut2, issued in the current cycle; returns in its Done cycle.
    task automatic xact(input string tag, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp);
        drive(rd, wr, a, d);
        #1 chk({tag, ".stall_T"}, 16'(stall2), 16'd1);
        step();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        #1 chk({tag, ".stall_T1"}, 16'(stall2), 16'd1);
        chk({tag, ".done_T1"}, 16'(done2), 16'd0);
        step();
        chk({tag, ".done"}, 16'(done2), 16'd1);
        chk({tag, ".dout"}, dout2, exp);
        chk({tag, ".err"}, 16'(err2), 16'd0);
        #1 chk({tag, ".stall_done"}, 16'(stall2), 16'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        step();
        step();
        chk("rst.dout", dout2, 16'h0000);
        chk("rst.done", 16'(done2), 16'd0);
        chk("rst.err", 16'(err2), 16'd0);
        chk("rst.stall", 16'(stall2), 16'd0);
        rst = 1'b1;
        step();

        xact("wr10", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        step();
        xact("rd10", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

        step();
        xact("wr04", 1'b0, 1'b1, 16'h0004, 16'h1234, 16'h0000);
        xact("b2b_rd04", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234);

        xact("wr20", 1'b0, 1'b1, 16'h0020, 16'h0C0C, 16'h0000);
        xact("wr08", 1'b0, 1'b1, 16'h0008, 16'h7777, 16'h0000);
        xact("wr30", 1'b0, 1'b1, 16'h0030, 16'h5555, 16'h0000);
        step();

        // Inputs that change during WAIT must be ignored.
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        #1 chk("busy.stall_T", 16'(stall2), 16'd1);
        step();
        drive(1'b0, 1'b1, 16'h0020, 16'hDEAD);
        #1 chk("busy.stall_T1", 16'(stall2), 16'd1);
        step();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        chk("busy.done", 16'(done2), 16'd1);
        chk("busy.dout", dout2, 16'hBEEF);
        xact("rd20_unchanged", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0C0C);

        step();
        drive(1'b1, 1'b1, 16'h0008, 16'h1111);
        #1 chk("rdwr.stall", 16'(stall2), 16'd0);
        step();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        chk("rdwr.err", 16'(err2), 16'd1);
        chk("rdwr.done", 16'(done2), 16'd0);
        #1 chk("rdwr.stall_next", 16'(stall2), 16'd0);
        step();
        chk("rdwr.err_clear", 16'(err2), 16'd0);
        xact("rd08_intact", 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h7777);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        step();
        drive(1'b1, 1'b0, 16'h0011, 16'h0000);
        #1 chk("misalign.stall", 16'(stall2), 16'd0);
        step();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        chk("misalign.err", 16'(err2), 16'd1);
        step();
        chk("misalign.no_done", 16'(done2), 16'd0);
        chk("misalign.err_clear", 16'(err2), 16'd0);
`else
        xact("rd11_word8", 1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF);
`endif

        // Reset one cycle after acceptance of a store: nothing committed, no Done.
        drive(1'b0, 1'b1, 16'h0030, 16'hAAAA);
        #1 chk("rstmid.stall_T", 16'(stall2), 16'd1);
        step();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        rst = 1'b0;
        step();
        chk("rstmid.dout", dout2, 16'h0000);
        chk("rstmid.done", 16'(done2), 16'd0);
        chk("rstmid.err", 16'(err2), 16'd0);
        chk("rstmid.stall", 16'(stall2), 16'd0);
        rst = 1'b1;
        step();
        chk("rstmid.no_done", 16'(done2), 16'd0);
        chk("rstmid.stall_after", 16'(stall2), 16'd0);
        xact("rd30_old", 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555);

        // Latency sweep across all three instances with one shared read.
        repeat (16) step();
        drive(1'b0, 1'b1, 16'h0040, 16'h4242);
        step();
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        repeat (16) step();
        drive(1'b1, 1'b0, 16'h0040, 16'h0000);
        for (int k = 0; k <= 16; k++) begin
            #1;
            chk($sformatf("L1.stall@%0d", k), 16'(stall1), 16'(k < 1));
            chk($sformatf("L2.stall@%0d", k), 16'(stall2), 16'(k < 2));
            chk($sformatf("L15.stall@%0d", k), 16'(stall15), 16'(k < 15));
            chk($sformatf("L1.done@%0d", k), 16'(done1), 16'(k == 1));
            chk($sformatf("L2.done@%0d", k), 16'(done2), 16'(k == 2));
            chk($sformatf("L15.done@%0d", k), 16'(done15), 16'(k == 15));
            chk($sformatf("L1.dout@%0d", k), dout1, (k == 1) ? 16'h4242 : 16'h0000);
            chk($sformatf("L2.dout@%0d", k), dout2, (k == 2) ? 16'h4242 : 16'h0000);
            chk($sformatf("L15.dout@%0d", k), dout15, (k == 15) ? 16'h4242 : 16'h0000);
            step();
            if (k == 0) drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
